// File: rtl/seq_frame_tx_if.sv
// Handshake and line bundle for the 1011 sync-pattern frame transmitter.
// The master side supplies payload words, the slave side (the transmitter)
// drives the serial line and its status flags.
interface seq_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load;
    logic                  ready;
    logic                  serial_out;
    logic                  frame_active;
    logic                  stuff_flag;
    logic                  done;

    modport master (
        output data_in,
        output load,
        input  ready,
        input  serial_out,
        input  frame_active,
        input  stuff_flag,
        input  done
    );

    modport slave (
        input  data_in,
        input  load,
        output ready,
        output serial_out,
        output frame_active,
        output stuff_flag,
        output done
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends the 1011 sync header, then the payload
// MSB first, inserting a 0 whenever the last three line bits are 101 so
// that 1011 can never appear on the line outside a header.
module seq_frame_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    seq_frame_tx_if.slave bus
);

    localparam logic [3:0] SYNC = 4'b1011;
    localparam int         CW   = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_PAYLOAD,
        S_GAP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic [1:0]            sync_idx;
    logic [2:0]            history;
    logic                  ready;

    // A new frame may start from idle or during the single gap cycle.
    assign ready     = (state == S_IDLE) || (state == S_GAP);
    assign bus.ready = ready;

    // Frame sequencer: each edge registers the bit that the line carries next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            shift_reg        <= '0;
            bit_cnt          <= '0;
            sync_idx         <= '0;
            history          <= '0;
            bus.serial_out   <= 1'b0;
            bus.frame_active <= 1'b0;
            bus.stuff_flag   <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done       <= 1'b0;
            bus.stuff_flag <= 1'b0;
            case (state)
                S_IDLE, S_GAP: begin
                    if (bus.load && ready) begin
                        shift_reg        <= bus.data_in;
                        bit_cnt          <= CW'(DATA_WIDTH);
                        sync_idx         <= 2'd2;
                        history          <= {2'b00, SYNC[3]};
                        bus.serial_out   <= SYNC[3];
                        bus.frame_active <= 1'b1;
                        state            <= S_SYNC;
                    end else begin
                        bus.serial_out   <= 1'b0;
                        bus.frame_active <= 1'b0;
                        state            <= S_IDLE;
                    end
                end
                S_SYNC: begin
                    bus.serial_out <= SYNC[sync_idx];
                    history        <= {history[1:0], SYNC[sync_idx]};
                    sync_idx       <= sync_idx - 2'd1;
                    if (sync_idx == 2'd0) begin
                        state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (bit_cnt == '0) begin
                        bus.serial_out   <= 1'b0;
                        bus.frame_active <= 1'b0;
                        bus.done         <= 1'b1;
                        history          <= {history[1:0], 1'b0};
                        state            <= S_GAP;
                    end else if (history == 3'b101) begin
                        bus.serial_out <= 1'b0;
                        bus.stuff_flag <= 1'b1;
                        history        <= {history[1:0], 1'b0};
                    end else begin
                        bus.serial_out <= shift_reg[DATA_WIDTH-1];
                        history        <= {history[1:0], shift_reg[DATA_WIDTH-1]};
                        shift_reg      <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt        <= bit_cnt - CW'(1);
                    end
                end
                default: begin
                    bus.serial_out   <= 1'b0;
                    bus.frame_active <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule
